// File: rtl/gray_step_if.sv
// Sample/status bundle between an upstream up/down counter and gray_step_monitor.
// master drives the counter samples and clear; slave is the monitor.
interface gray_step_if #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
) ();
    logic             in_valid;
    logic             in_load;
    logic [WIDTH-1:0] in_value;
    logic             clear;
    logic [WIDTH-1:0] gray_out;
    logic             gray_valid;
    logic             step_up;
    logic             step_down;
    logic             wrap;
    logic             step_err;
    logic [ERR_W-1:0] err_count;
    logic             fault;

    modport master (
        output in_valid, in_load, in_value, clear,
        input  gray_out, gray_valid, step_up, step_down, wrap, step_err, err_count, fault
    );

    modport slave (
        input  in_valid, in_load, in_value, clear,
        output gray_out, gray_valid, step_up, step_down, wrap, step_err, err_count, fault
    );
endinterface

// File: rtl/gray_step_monitor.sv
// Gray re-encoder and transition classifier for a 0..MAXVAL up/down wrap counter.
// Define GRAY_STICKY_FAULT_EN to latch the first illegal transition into a FAULT state.
module gray_step_monitor #(
    parameter int WIDTH  = 3,
    parameter int MAXVAL = 4,
    parameter int ERR_W  = 8
) (
    input  logic       clk,
    input  logic       reset,
    gray_step_if.slave bus,
    output logic [1:0] fsm_state
);
    // Handshake: a sample is accepted on any rising edge where in_valid=1 and
    // clear=0; there is no backpressure, and every pulse output answers the
    // sample accepted on the previous edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAXVAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [WIDTH-1:0] gray_q, gray_nxt;
    logic [ERR_W-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic             gv_q, gv_nxt;
    logic             up_q, up_nxt;
    logic             dn_q, dn_nxt;
    logic             wrap_q, wrap_nxt;
    logic             err_q, err_nxt;

    logic quiet, up_step, up_wrap, dn_step, dn_wrap, is_up, is_down, illegal;

    always_comb begin
        quiet   = bus.in_load || (bus.in_value == prev);
        up_step = (prev < MAX_V) && (bus.in_value == prev + ONE);
        up_wrap = (prev >= MAX_V) && (bus.in_value == '0);
        dn_step = (prev != '0) && (bus.in_value == prev - ONE);
        dn_wrap = (prev == '0) && (bus.in_value == MAX_V);
        // Up wins over down where both could match (only possible for tiny MAXVAL).
        is_up   = !quiet && (up_step || up_wrap);
        is_down = !quiet && !is_up && (dn_step || dn_wrap);
        illegal = !quiet && !is_up && !is_down;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ERR_W'(1);
    end

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        gray_nxt  = gray_q;
        cnt_nxt   = cnt_q;
        gv_nxt    = 1'b0;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (bus.clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (bus.in_valid) begin
            gray_nxt = bus.in_value ^ (bus.in_value >> 1);
            gv_nxt   = 1'b1;
            prev_nxt = bus.in_value;
            case (state)
                IDLE: state_nxt = TRACK;
                TRACK: begin
                    if (illegal) begin
                        err_nxt = 1'b1;
                        cnt_nxt = cnt_inc;
`ifdef GRAY_STICKY_FAULT_EN
                        state_nxt = FAULT;
`endif
                    end else begin
                        up_nxt   = is_up;
                        dn_nxt   = is_down;
                        wrap_nxt = (is_up && up_wrap && !up_step) || (is_down && dn_wrap && !dn_step);
                    end
                end
                FAULT: begin
`ifdef GRAY_STICKY_FAULT_EN
                    if (illegal) begin
                        err_nxt = 1'b1;
                        cnt_nxt = cnt_inc;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            prev   <= '0;
            gray_q <= '0;
            cnt_q  <= '0;
            gv_q   <= 1'b0;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            prev   <= prev_nxt;
            gray_q <= gray_nxt;
            cnt_q  <= cnt_nxt;
            gv_q   <= gv_nxt;
            up_q   <= up_nxt;
            dn_q   <= dn_nxt;
            wrap_q <= wrap_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.gray_out   = gray_q;
    assign bus.gray_valid = gv_q;
    assign bus.step_up    = up_q;
    assign bus.step_down  = dn_q;
    assign bus.wrap       = wrap_q;
    assign bus.step_err   = err_q;
    assign bus.err_count  = cnt_q;
`ifdef GRAY_STICKY_FAULT_EN
    assign bus.fault = (state == FAULT);
`else
    assign bus.fault = 1'b0;
`endif
    assign fsm_state = state;
endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed scenarios plus randomized samples against a transaction-level model
// of the gray_step_monitor classification rules.
module tb_gray_step_monitor;
    localparam int WIDTH  = 3;
    localparam int MAXVAL = 4;
    localparam int ERR_W  = 2;
    localparam int NVAL   = 1 << WIDTH;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] fsm_state;

    gray_step_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    gray_step_monitor #(.WIDTH(WIDTH), .MAXVAL(MAXVAL), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int gtab[NVAL];
    bit m_track, m_fault;
    int m_prev, m_gray, m_err;
    int e_gv, e_up, e_dn, e_wrap, e_se;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reflected Gray built by mirroring: each new bit appends the list reversed.
    task automatic build_gray_table();
        int n = 1;
        gtab[0] = 0;
        for (int b = 0; b < WIDTH; b++) begin
            for (int i = 0; i < n; i++) gtab[2*n-1-i] = gtab[i] | (1 << b);
            n = n * 2;
        end
    endtask

    task automatic model_step(input bit rst, input bit clr, input bit vld, input bit ld, input int v);
        bit up, dn, hold, legal;
        e_gv = 0; e_up = 0; e_dn = 0; e_wrap = 0; e_se = 0;
        if (rst) begin
            m_track = 0; m_fault = 0; m_prev = 0; m_gray = 0; m_err = 0;
        end else if (clr) begin
            m_track = 0; m_fault = 0; m_err = 0;
        end else if (vld) begin
            e_gv = 1;
            m_gray = gtab[v];
            if (m_track) begin
                hold  = (v == m_prev);
                up    = (m_prev < MAXVAL) ? (v == m_prev + 1) : (v == 0);
                dn    = (m_prev > 0) ? (v == m_prev - 1) : (v == MAXVAL);
                legal = ld || hold || up || dn;
                if (!legal) begin
                    e_se = 1;
                    if (m_err < ERR_MAX) m_err++;
                end else if (!m_fault && !ld && !hold) begin
                    e_up   = up;
                    e_dn   = !up && dn;
                    e_wrap = up ? (m_prev >= MAXVAL) : (m_prev == 0);
                end
`ifdef GRAY_STICKY_FAULT_EN
                if (!legal) m_fault = 1;
`endif
            end
            m_track = 1;
            m_prev = v;
        end
    endtask

    task automatic cycle(input bit rst, input bit clr, input bit vld, input bit ld, input int v);
        @(negedge clk);
        reset        = rst;
        bus.clear    = clr;
        bus.in_valid = vld;
        bus.in_load  = ld;
        bus.in_value = WIDTH'(v);
        model_step(rst, clr, vld, ld, v);
        @(posedge clk);
        #1;
        check("gray_out",   int'(bus.gray_out),   m_gray);
        check("gray_valid", int'(bus.gray_valid), e_gv);
        check("step_up",    int'(bus.step_up),    e_up);
        check("step_down",  int'(bus.step_down),  e_dn);
        check("wrap",       int'(bus.wrap),       e_wrap);
        check("step_err",   int'(bus.step_err),   e_se);
        check("err_count",  int'(bus.err_count),  m_err);
        check("fault",      int'(bus.fault),      int'(m_fault));
    endtask

    task automatic sample(input int v);
        cycle(0, 0, 1, 0, v);
    endtask

    int seq1[6] = '{0, 1, 2, 3, 4, 0};
    int bad5[4] = '{3, 6, 1, 5};

    initial begin
        int r, v;
        bus.clear = 0; bus.in_valid = 0; bus.in_load = 0; bus.in_value = '0;
        build_gray_table();
        m_track = 0; m_fault = 0; m_prev = 0; m_gray = 0; m_err = 0;

        // Reset for two cycles, then a full up count with wrap
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        foreach (seq1[i]) sample(seq1[i]);
        // Down count from 0: wrap to MAXVAL, then plain steps
        sample(4); sample(3); sample(2);
        // Illegal jump 1->3, then 3->4
        sample(1); sample(3); sample(4);
        cycle(0, 0, 0, 0, 0);
        // Load above MAXVAL then wrap out of it
        cycle(0, 1, 0, 0, 0);
        sample(2);
        cycle(0, 0, 1, 1, 6);
        sample(0);
        // Saturating error count, then clear colliding with a sample
        cycle(0, 1, 0, 0, 0);
        sample(0);
        foreach (bad5[i]) sample(bad5[i]);
        cycle(0, 1, 1, 0, 2);
        sample(2);
        // Reset while faulted (sticky) or tracking, with a sample present
        sample(5);
        cycle(1, 0, 1, 0, 3);
        cycle(0, 0, 0, 0, 0);

        // Randomized samples biased towards legal steps
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                cycle(1, 0, $urandom_range(0, 1), 0, $urandom_range(0, NVAL - 1));
                continue;
            end
            if (r < 5) begin
                cycle(0, 1, $urandom_range(0, 1), 0, $urandom_range(0, NVAL - 1));
                continue;
            end
            if (r < 20) begin
                cycle(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, NVAL - 1));
                continue;
            end
            r = $urandom_range(0, 9);
            if (r < 4)      v = (m_prev >= MAXVAL) ? 0 : m_prev + 1;
            else if (r < 7) v = (m_prev == 0) ? MAXVAL : m_prev - 1;
            else if (r < 8) v = m_prev;
            else            v = $urandom_range(0, NVAL - 1);
            cycle(0, 0, 1, ($urandom_range(0, 9) == 0), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
